regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single regfile write port (write enable, 5-bit register select, 32-bit data) among
//  NREQ requesters: CPU writeback, controller-input loader, game-timer updater, and so on.
//  Arbitration is round-robin, with optional locked bursts. The write-port outputs are registered.
//  Sits between the requesters and the regfile write port.
// PARAMETERS
//  NREQ       4   number of requesters (2..8)
//  ADDR_W     5   register-select width
//  DATA_W     32  write-data width
//  MAX_BURST  4   max consecutive grants one locked requester may hold (1..15)
// PORTS
//  clock       in   1             system clock; all state updates on the rising edge
//  ctrl_reset  in   1             asynchronous, active-low reset
//  req_valid   in   NREQ          requester i has a write pending
//  req_lock    in   NREQ          requester i asks to keep the grant next cycle (burst)
//  req_reg     in   NREQ*ADDR_W   target register; slice i = [i*ADDR_W +: ADDR_W]
//  req_data    in   NREQ*DATA_W   write data; slice i = [i*DATA_W +: DATA_W]
//  req_ready   out  NREQ          one-hot or zero; the write from requester i is accepted this cycle
//  wr_enable   out  1             regfile ctrl_writeEnable (registered)
//  wr_reg      out  ADDR_W        regfile ctrl_writeReg (registered)
//  wr_data     out  DATA_W        regfile data_writeReg (registered)
//  grant_id    out  3             index of the last accepted requester (registered)
//  burst_active out 1             state == BURST
// BEHAVIOUR
//  - Reset (ctrl_reset=0, async): state=IDLE, rr_ptr=0, burst_cnt=0, wr_enable=0, wr_reg=0,
//    wr_data=0, grant_id=0, burst_active=0. req_ready=0 while reset is asserted.
//  - Handshake: a transfer occurs when req_valid[i] & req_ready[i].
//    - req_ready is combinational from req_valid, state, rr_ptr and burst_owner.
//    - At most one bit of req_ready is set per cycle.
//    - A requester holds its valid, reg and data until it is accepted; valid never depends on ready.
//  - Latency: a transfer in cycle N drives wr_enable, wr_reg and wr_data in cycle N+1, for one cycle.
//    With no transfer in cycle N, wr_enable=0 in N+1; wr_reg and wr_data hold their last values.
//  - Register 0: a transfer with req_reg==0 is accepted normally (ready=1, grant_id updates),
//    but wr_enable stays 0 for that write.
//  - Round-robin, states IDLE and GRANT:
//    - Grant the first valid requester at or after rr_ptr, searching upward modulo NREQ.
//    - On a transfer by requester k: rr_ptr <= (k+1) mod NREQ.
//    - With no valid requester, rr_ptr is unchanged.
//  - FSM states: IDLE, GRANT, BURST.
//    - IDLE -> GRANT on any transfer that has req_lock[k]=0.
//    - IDLE/GRANT -> BURST on a transfer by k with req_lock[k]=1:
//      burst_owner <= k, burst_cnt <= 1, rr_ptr is not advanced.
//    - GRANT -> IDLE on a cycle with no transfer. GRANT -> GRANT on a non-locked transfer.
//    - In BURST only burst_owner may be granted; req_ready[owner] = req_valid[owner].
//      - A transfer with lock=1 and burst_cnt < MAX_BURST: burst_cnt++.
//      - A transfer with lock=0, or a transfer that brings burst_cnt to MAX_BURST: leave to GRANT,
//        rr_ptr <= owner+1, burst_cnt <= 0.
//      - A cycle in BURST with req_valid[owner]=0: leave to IDLE, rr_ptr <= owner+1.
//        No other requester is granted that cycle.
//    - Total burst length is therefore at most MAX_BURST transfers. Fairness bound: any valid
//      requester is granted within (NREQ-1)*MAX_BURST+1 cycles.
//  - Simultaneous events:
//    - req_lock on a non-granted requester is ignored.
//    - A requester whose valid drops while not granted loses nothing; pending is not latched.
//  - Reset mid-burst: immediate return to IDLE. An output write launched before reset is cancelled
//    (wr_enable forced to 0 asynchronously).
//  - grant_id width is fixed at 3; the upper bits are 0 when NREQ < 8.
// TESTING
//  1. Reset with all valid high: wr_enable=0, req_ready=0; release, first edge -> ready=0001,
//     then wr_enable=1 on the next cycle.
//  2. NREQ=4, all valid continuously, lock=0, reg=i+1, data=0xA0+i:
//     grants 0,1,2,3,0,... and wr_reg=1,2,3,4 with 1-cycle lag.
//  3. Requester 2 writes reg 0, data 0xDEADBEEF: ready[2]=1, grant_id=2, wr_enable stays 0.
//  4. Requester 1 locked with 6 writes pending, requester 3 valid, MAX_BURST=4:
//     r1 granted exactly 4 consecutive cycles, then r3 granted.
//  5. Requester 0 in BURST drops valid for one cycle: FSM->IDLE, next grant goes to requester 1
//     if valid.
//  6. Assert ctrl_reset asynchronously mid-burst (between edges): wr_enable and burst_active go to 0
//     before the next edge; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single regfile write port. It supports locked bursts of up to
// MAX_BURST transfers. The write port (enable/select/data) and grant_id are registered, so an
// accepted request appears on the regfile port one cycle after it is accepted.
//
// Handshake: a write transfers in any cycle where req_valid[i] & req_ready[i] are both high.
// req_ready is combinational from req_valid, the FSM state, rr_ptr and the burst owner.
// At most one ready bit is set in a cycle. A requester holds its valid, reg and data until it
// is accepted, and its valid never waits on ready.
module regfile_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*ADDR_W-1:0] req_reg,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wr_enable,
  output logic [ADDR_W-1:0]      wr_reg,
  output logic [DATA_W-1:0]      wr_data,
  output logic [2:0]             grant_id,
  output logic                   burst_active,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          owner_q, owner_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic                wr_enable_q;
  logic [ADDR_W-1:0]   wr_reg_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [2:0]          grant_id_q;

  logic [NREQ-1:0]     ready_raw;
  logic [2:0]          win;
  logic                found;
  logic                xfer;
  logic                win_lock;
  logic [ADDR_W-1:0]   win_reg;
  logic [DATA_W-1:0]   win_data;
  int                  j;

  // Wraps a requester index to the next one, modulo NREQ.
  function automatic logic [2:0] next_idx(input logic [2:0] k);
    if (int'(k) >= NREQ - 1) return 3'd0;
    return k + 3'd1;
  endfunction

  // Pick the winner: the burst owner only while bursting, else the first valid at/after rr_ptr.
  always_comb begin
    ready_raw = '0;
    win       = '0;
    found     = 1'b0;
    j         = 0;
    if (state_q == ST_BURST) begin
      for (int i = 0; i < NREQ; i++) begin
        if (3'(i) == owner_q) ready_raw[i] = req_valid[i];
      end
      win = owner_q;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        j = int'(rr_ptr_q) + off;
        if (j >= NREQ) j = j - NREQ;
        for (int i = 0; i < NREQ; i++) begin
          if (i == j && !found && req_valid[i]) begin
            found        = 1'b1;
            ready_raw[i] = 1'b1;
            win          = 3'(i);
          end
        end
      end
    end
  end

  // Select the winning requester's lock, target register and data.
  always_comb begin
    win_lock = 1'b0;
    win_reg  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        win_lock = req_lock[i];
        win_reg  = req_reg[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer      = |ready_raw;
  assign req_ready = ctrl_reset ? ready_raw : '0;

  // Next-state logic for the IDLE/GRANT/BURST FSM, round-robin pointer and burst counter.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE, ST_GRANT: begin
        if (xfer) begin
          // A one-transfer burst limit makes a lock meaningless, so treat it as a plain grant.
          if (win_lock && MAX_BURST > 1) begin
            state_d     = ST_BURST;
            owner_d     = win;
            burst_cnt_d = 4'd1;
          end else begin
            state_d  = ST_GRANT;
            rr_ptr_d = next_idx(win);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          if (win_lock && (int'(burst_cnt_q) + 1 < MAX_BURST)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else begin
            state_d     = ST_GRANT;
            rr_ptr_d    = next_idx(owner_q);
            burst_cnt_d = 4'd0;
          end
        end else begin
          state_d     = ST_IDLE;
          rr_ptr_d    = next_idx(owner_q);
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // State and registered write port; reset also cancels a write already launched.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      wr_enable_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      // Writes to register 0 are accepted but never reach the regfile.
      wr_enable_q <= xfer && (win_reg != '0);
      if (xfer) begin
        wr_reg_q   <= win_reg;
        wr_data_q  <= win_data;
        grant_id_q <= win;
      end
    end
  end

  assign wr_enable    = wr_enable_q;
  assign wr_reg       = wr_reg_q;
  assign wr_data      = wr_data_q;
  assign grant_id     = grant_id_q;
  assign burst_active = (state_q == ST_BURST);
  assign dbg_state    = state_q;

endmodule
